// File: rtl/freq_meter.sv
`timescale 1ns/1ps
// freq_meter: counts rising edges of an asynchronous pulse train over a fixed gate window
// and measures the clk_in-cycle distance between consecutive edges.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned PER_W       = 20
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] edge_count,
  output logic [PER_W-1:0] period,
  output logic             valid,
  output logic             overflow,
  output logic             no_signal
);

  localparam int unsigned       GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [PER_W-1:0]  PER_MAX   = '1;

  typedef enum logic {IDLE, GATE} state_t;

  state_t state, state_nxt;

  logic              s1, s2, s3;
  logic              strobe;
  logic              running;
  logic              gate_end;
  logic [GATE_W-1:0] gate_tmr;
  logic [CNT_W-1:0]  edge_cnt, cnt_nxt;
  logic              ovf, ovf_nxt;
  logic [PER_W-1:0]  per_tmr, per_reg, per_nxt;
  logic              armed;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [PER_W-1:0] sat_inc_per(input logic [PER_W-1:0] v);
    return (v == PER_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)  state_nxt = GATE;
      GATE:    if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage: three-flop synchronizer; s3 only exists to form the rising-edge strobe.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign strobe   = s2 & ~s3;
  assign running  = (state == GATE) && en;
  assign gate_end = running && (gate_tmr == GATE_LAST);

  // A timer sitting at saturation means the gap is unmeasurable, so it never yields a period.
  always_comb begin
    cnt_nxt = strobe ? sat_inc_cnt(edge_cnt) : edge_cnt;
    ovf_nxt = ovf | (strobe & (edge_cnt == CNT_MAX));
    per_nxt = per_reg;
    if (strobe && armed && (per_tmr != PER_MAX))
      per_nxt = per_tmr + 1'b1;
  end

  // Stage: gate window; the final cycle hands off to the next gate with no dead cycle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      gate_tmr <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else if (!running || gate_end) begin
      gate_tmr <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      gate_tmr <= gate_tmr + 1'b1;
      edge_cnt <= cnt_nxt;
      ovf      <= ovf_nxt;
    end
  end

  // Stage: edge-to-edge period timer and live no_signal flag.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      per_tmr   <= '0;
      per_reg   <= '0;
      armed     <= 1'b0;
      no_signal <= 1'b0;
    end else if (!running) begin
      per_tmr   <= '0;
      armed     <= 1'b0;
      no_signal <= 1'b0;
    end else begin
      per_reg <= per_nxt;
      if (strobe) begin
        per_tmr   <= '0;
        armed     <= 1'b1;
        no_signal <= 1'b0;
      end else if (per_tmr == PER_MAX) begin
        armed     <= 1'b0;
        no_signal <= 1'b1;
      end else begin
        per_tmr <= sat_inc_per(per_tmr);
      end
    end
  end

  // Stage: published results, updated only when a gate completes.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      edge_count <= '0;
      period     <= '0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
    end else begin
      valid <= gate_end;
      if (gate_end) begin
        edge_count <= cnt_nxt;
        overflow   <= ovf_nxt;
        period     <= per_nxt;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
// Bench for freq_meter: a table of square-wave scenarios plus directed sequences for
// timeout, gate-boundary alignment, en drop, reset and counter saturation.
module tb_freq_meter;

  localparam int GATE = 5000;
  localparam int PW   = 12;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst = 1'b1, en = 1'b0, sig = 1'b0;
  logic [25:0]   ec;
  logic [PW-1:0] per;
  logic          vld, ovf, nos;

  logic          rst2 = 1'b1, en2 = 1'b0, sig2 = 1'b0;
  logic [1:0]    ec2;
  logic [PW-1:0] per2;
  logic          vld2, ovf2, nos2;

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(26), .PER_W(PW)) dut (
    .clk_in(clk), .rst(rst), .en(en), .sig_in(sig),
    .edge_count(ec), .period(per), .valid(vld), .overflow(ovf), .no_signal(nos)
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(2), .PER_W(PW)) dut_sat (
    .clk_in(clk), .rst(rst2), .en(en2), .sig_in(sig2),
    .edge_count(ec2), .period(per2), .valid(vld2), .overflow(ovf2), .no_signal(nos2)
  );

  int total = 0, bad = 0;
  int half = 0, hc = 0, half2 = 0, hc2 = 0;
  bit dut2_done = 1'b0;

  typedef struct {
    int half;
    int ngates;
    int cnt_lo;
    int cnt_hi;
    int exp_per;
    int sum_lo;
    int sum_hi;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (half != 0) begin
      hc++;
      if (hc >= half) begin
        sig = ~sig;
        hc  = 0;
      end
    end
  endtask

  task automatic tick2();
    @(negedge clk);
    if (half2 != 0) begin
      hc2++;
      if (hc2 >= half2) begin
        sig2 = ~sig2;
        hc2  = 0;
      end
    end
  endtask

  task automatic wait_valid(input string name, input int lim, output int n);
    bit ok;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < lim) begin
      tick();
      n++;
      if (vld) ok = 1'b1;
    end
    check(name, int'(ok), 1);
  endtask

  task automatic wait_valid2(input string name, input int lim);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < lim) begin
      tick2();
      n++;
      if (vld2) ok = 1'b1;
    end
    check(name, int'(ok), 1);
  endtask

  task automatic count_valid(input int cycles, output int nv);
    nv = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (vld) nv++;
    end
  endtask

  // Saturating-counter instance, CNT_W=2, runs alongside the main sequence.
  initial begin
    repeat (3) tick2();
    rst2  = 1'b0;
    half2 = 50;
    en2   = 1'b1;
    wait_valid2("sat_gate1_valid", 6000);
    check("sat_edge_count", int'(ec2), 3);
    check("sat_overflow", int'(ovf2), 1);
    check("sat_period", int'(per2), 100);
    half2 = 0;
    sig2  = 1'b0;
    wait_valid2("sat_gate2_valid", 6000);
    wait_valid2("sat_gate3_valid", 6000);
    check("sat_static_count", int'(ec2), 0);
    check("sat_static_ovf", int'(ovf2), 0);
    check("sat_static_period", int'(per2), 100);
    check("sat_static_nosig", int'(nos2), 1);
    dut2_done = 1'b1;
  end

  initial begin
    vec_t tbl[2];
    int   n, nv, sum;

    tbl[0] = '{500, 2, 5, 5, 1000, 10, 10};
    tbl[1] = '{658, 10, 3, 4, 1316, 37, 38};

    repeat (2) tick();
    check("rst_edge_count", int'(ec), 0);
    check("rst_period", int'(per), 0);
    check("rst_valid", int'(vld), 0);
    check("rst_overflow", int'(ovf), 0);
    check("rst_no_signal", int'(nos), 0);
    rst = 1'b0;
    tick();

    for (int t = 0; t < 2; t++) begin
      en = 1'b0;
      tick();
      half = tbl[t].half;
      hc   = 0;
      sig  = 1'b0;
      repeat (20) tick();
      en  = 1'b1;
      sum = 0;
      for (int g = 0; g < tbl[t].ngates; g++) begin
        wait_valid("wave_valid", 6000, n);
        if (g > 0) check("wave_interval", n, GATE);
        check_rng("wave_edge_count", int'(ec), tbl[t].cnt_lo, tbl[t].cnt_hi);
        check("wave_period", int'(per), tbl[t].exp_per);
        check("wave_overflow", int'(ovf), 0);
        sum += int'(ec);
      end
      check_rng("wave_sum", sum, tbl[t].sum_lo, tbl[t].sum_hi);
    end

    // Timeout: signal goes quiet at gate cycle 0 of a running gate.
    half = 0;
    sig  = 1'b0;
    repeat (2700) tick();
    check("nosig_before_sat", int'(nos), 0);
    repeat (1500) tick();
    check("nosig_after_sat", int'(nos), 1);
    repeat (400) tick();
    sig = 1'b1;
    repeat (10) tick();
    check("nosig_cleared", int'(nos), 0);
    repeat (290) tick();
    sig = 1'b0;
    repeat (100) tick();
    check("nosig_gate_valid", int'(vld), 1);
    check("nosig_no_bogus_period", int'(per), 1316);
    check_rng("nosig_edge_count", int'(ec), 1, 2);
    repeat (200) tick();
    sig = 1'b1;
    wait_valid("rearm_valid", 6000, n);
    check("rearm_period", int'(per), 600);
    check("rearm_edge_count", int'(ec), 1);

    // Strobe lands on the last gate cycle.
    sig = 1'b0;
    repeat (4997) tick();
    sig = 1'b1;
    wait_valid("align_valid", 10, n);
    check("align_latency", n, 3);
    check("align_edge_count", int'(ec), 1);
    check("align_period", int'(per), 600);

    // en drops mid-gate after two more edges.
    repeat (100) tick();
    sig = 1'b0;
    repeat (400) tick();
    sig = 1'b1;
    repeat (400) tick();
    sig = 1'b0;
    repeat (400) tick();
    sig = 1'b1;
    repeat (1200) tick();
    en = 1'b0;
    count_valid(2600, nv);
    check("endrop_no_valid", nv, 0);
    check("endrop_edge_count", int'(ec), 1);
    check("endrop_period", int'(per), 600);
    check("endrop_overflow", int'(ovf), 0);
    check("endrop_no_signal", int'(nos), 0);

    // Asynchronous reset in the middle of a gate.
    en = 1'b1;
    repeat (2000) tick();
    rst = 1'b1;
    #1;
    check("midrst_edge_count", int'(ec), 0);
    check("midrst_period", int'(per), 0);
    check("midrst_valid", int'(vld), 0);
    check("midrst_overflow", int'(ovf), 0);
    check("midrst_no_signal", int'(nos), 0);
    en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    count_valid(5100, nv);
    check("idle_no_valid", nv, 0);
    check("idle_edge_count", int'(ec), 0);

    check("sat_sequence_done", int'(dut2_done), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
